// File: rtl/ram_32x32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_32x32_pkg
// Description : Shared width/depth defaults and word type for the 32x32 RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_32x32_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 5;
    localparam int c_DEPTH  = 2 ** c_ADDR_W;

    typedef logic [c_DATA_W-1:0] mem_word_t;

endpackage : ram_32x32_pkg
`default_nettype wire

// File: rtl/ram_32x32_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_32x32_if
// Description : Control/address/data bundle between a RAM user and the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_32x32_if
    import ram_32x32_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
);

    logic              ena;
    logic              wena;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        output ena,
        output wena,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  ena,
        input  wena,
        input  addr,
        input  data_in,
        output data_out
    );

endinterface : ram_32x32_if
`default_nettype wire

// File: rtl/ram_32x32_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ram_ctrl_decode
// Description : Turns chip-enable / write-enable into write and read strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_ctrl_decode (
    input  wire logic i_ena,
    input  wire logic i_wena,
    output logic      o_we,
    output logic      o_re
);

    always_comb begin
        o_we = i_ena &  i_wena;
        o_re = i_ena & ~i_wena;
    end

endmodule : ram_ctrl_decode
`default_nettype wire

// File: rtl/ram_32x32.sv
`default_nettype none
// ============================================================================
// Module      : ram_32x32
// Description : Single-port synchronous RAM with registered read and
//               asynchronous clear of the whole array.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_32x32
    import ram_32x32_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  wire logic   clk,
    input  wire logic   rst,
    ram_32x32_if.slave  bus
);

    logic                         w_we;
    logic                         w_re;
    logic [DEPTH-1:0][DATA_W-1:0] w_words;

    ram_ctrl_decode u_decode (
        .i_ena  (bus.ena),
        .i_wena (bus.wena),
        .o_we   (w_we),
        .o_re   (w_re)
    );

    // One register per word so the whole array can be cleared asynchronously;
    // a vendor RAM primitive cannot do that.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_W-1:0] r_word;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_word <= '0;
                end else if (w_we && (bus.addr == ADDR_W'(gi))) begin
                    r_word <= bus.data_in;
                end
            end

            assign w_words[gi] = r_word;
        end
    endgenerate

    // Output only updates on a read edge; writes leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_out <= '0;
        end else if (w_re) begin
            bus.data_out <= w_words[bus.addr];
        end
    end

endmodule : ram_32x32
`default_nettype wire

// File: tb/tb_ram_32x32.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_32x32
// Description : Directed plus random self-checking bench for ram_32x32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_32x32;
    import ram_32x32_pkg::*;

    logic clk;
    logic rst;

    ram_32x32_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    ram_32x32 #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_word_t model_mem [32];
    mem_word_t model_dout;
    int        n_checks = 0;
    int        n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        model_dout = '0;
    endtask

    // Drive one cycle at the falling edge, let the rising edge act, then
    // compare the output at the next falling edge.
    task automatic op(input string tag, input logic e, input logic w,
                      input logic [4:0] a, input logic [31:0] d);
        bus.ena = e; bus.wena = w; bus.addr = a; bus.data_in = d;
        @(posedge clk);
        if (e && !w)     model_dout = model_mem[a];
        else if (e && w) model_mem[a] = d;
        @(negedge clk);
        check(tag, bus.data_out, model_dout);
    endtask

    initial begin
        rst = 1'b0;
        bus.ena = 1'b0; bus.wena = 1'b0; bus.addr = '0; bus.data_in = '0;
        model_reset();
        #1 rst = 1'b1;
        #2 check("reset_dout", bus.data_out, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i <= 8; i++) op("rd_after_reset", 1'b1, 1'b0, 5'(i), 32'hFFFF_FFFF);

        op("wr_0", 1'b1, 1'b1, 5'd0, 32'h1234_5678);
        check("no_write_through", bus.data_out, 32'h0);
        op("rd_0_first", 1'b1, 1'b0, 5'd0, 32'h0);
        check("rd_0_value", bus.data_out, 32'h1234_5678);
        op("wr_0_again", 1'b1, 1'b1, 5'd0, 32'h8765_4321);
        op("rd_0_last_wins", 1'b1, 1'b0, 5'd0, 32'h0);
        check("last_write_wins", bus.data_out, 32'h8765_4321);
        op("rd_ignores_din", 1'b1, 1'b0, 5'd0, 32'h7777_7777);
        op("rd_0_unchanged", 1'b1, 1'b0, 5'd0, 32'h0);
        check("din_ignored", bus.data_out, 32'h8765_4321);

        op("idle_0", 1'b0, 1'b1, 5'd1, 32'hDEAD_BEEF);
        op("idle_1", 1'b0, 1'b0, 5'd2, 32'hDEAD_BEEF);
        check("idle_holds_dout", bus.data_out, 32'h8765_4321);
        op("rd_1_after_idle", 1'b1, 1'b0, 5'd1, 32'h0);
        check("idle_no_write", bus.data_out, 32'h0);

        // Random traffic against the array model
        for (int n = 0; n < 300; n++) begin
            op("random", ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 31)), $urandom);
        end
        for (int i = 0; i < 32; i++) op("sweep", 1'b1, 1'b0, 5'(i), 32'h0);

        op("wr_31", 1'b1, 1'b1, 5'd31, 32'hA5A5_A5A5);
        op("rd_31", 1'b1, 1'b0, 5'd31, 32'h0);
        check("rd_31_value", bus.data_out, 32'hA5A5_A5A5);

        // Asynchronous reset between edges, with a write pending on the edge
        bus.ena = 1'b1; bus.wena = 1'b1; bus.addr = 5'd31; bus.data_in = 32'h1111_2222;
        #2 rst = 1'b1;
        #1 check("async_reset_dout", bus.data_out, 32'h0);
        model_reset();
        @(negedge clk);
        check("reset_held_dout", bus.data_out, 32'h0);
        rst = 1'b0;
        op("rd_31_after_reset", 1'b1, 1'b0, 5'd31, 32'h0);
        check("rd_31_cleared", bus.data_out, 32'h0);
        for (int i = 0; i < 32; i++) op("cleared_sweep", 1'b1, 1'b0, 5'(i), 32'h0);

        op("wr_first_edge", 1'b1, 1'b1, 5'd7, 32'hCAFE_F00D);
        op("rd_first_edge", 1'b1, 1'b0, 5'd7, 32'h0);
        check("post_reset_normal", bus.data_out, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ram_32x32
`default_nettype wire
